// File: rtl/word_unpacker_pkg.sv
// Shared types and default sizes for the word-to-byte unpacker.
// Imported by word_unpacker and its testbench.
package word_unpacker_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } wu_state_t;

  localparam int BYTE_W_DEF         = 8;
  localparam int BYTES_PER_WORD_DEF = 4;
  localparam int WORD_W             = BYTE_W_DEF * BYTES_PER_WORD_DEF;
  localparam int CNT_W              = $clog2(BYTES_PER_WORD_DEF);

endpackage : word_unpacker_pkg

// File: rtl/word_unpacker.sv
// Splits each accepted word into bytes, low lane first, one byte per sink handshake.
// Optional macro WORD_UNPACKER_PREFETCH_EN lets the next word load alongside the last byte.
module word_unpacker
  import word_unpacker_pkg::*;
#(
  parameter int BYTE_W         = BYTE_W_DEF,
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF  // power of 2, >= 2
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [BYTE_W*BYTES_PER_WORD-1:0]  i_word,
  input  logic                              i_word_valid,
  output logic                              o_word_ready,
  output logic [BYTE_W-1:0]                 o_data,
  output logic [$clog2(BYTES_PER_WORD)-1:0] o_address,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic                              o_last,
  output wu_state_t                         dbg_state
);

  localparam int              W_L       = BYTE_W * BYTES_PER_WORD;
  localparam int              CW_L      = $clog2(BYTES_PER_WORD);
  localparam logic [CW_L-1:0] LAST_LANE = CW_L'(BYTES_PER_WORD - 1);

  wu_state_t       state_q;
  wu_state_t       state_d;
  logic [W_L-1:0]  shift_q;
  logic [CW_L-1:0] cnt_q;
  logic            ready_q;
  logic            lane_last;
  logic            word_accept;
  logic            byte_xfer;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the source holds its payload stable while valid & !ready.
  assign word_accept = i_word_valid & o_word_ready;
  assign byte_xfer   = o_valid & i_ready;
  assign lane_last   = (cnt_q == LAST_LANE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (word_accept) state_d = SEND;
      end
      SEND: begin
        // A word accepted with the last byte keeps the FSM in SEND.
        if (byte_xfer && lane_last) state_d = word_accept ? SEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bytes leave from the bottom of the shift register, so no lane mux is needed.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      ready_q <= (state_d == IDLE);
      if (word_accept) begin
        shift_q <= i_word;
        cnt_q   <= '0;
      end else if (byte_xfer) begin
        shift_q <= shift_q >> BYTE_W;
        cnt_q   <= cnt_q + CW_L'(1);
      end
    end
  end

  always_comb begin
    o_valid   = 1'b0;
    o_last    = 1'b0;
    o_data    = shift_q[BYTE_W-1:0];
    o_address = cnt_q;
    dbg_state = state_q;
    if (state_q == SEND) begin
      o_valid = 1'b1;
      o_last  = lane_last;
    end
`ifdef WORD_UNPACKER_PREFETCH_EN
    o_word_ready = ready_q | (o_last & i_ready);
`else
    o_word_ready = ready_q;
`endif
  end

endmodule : word_unpacker

// File: tb/tb_word_unpacker.sv
// Bench for word_unpacker: byte-queue reference model plus word scoreboard.
// Builds with or without WORD_UNPACKER_PREFETCH_EN.
module tb_word_unpacker;
  import word_unpacker_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_word = '0;
  logic        i_word_valid = 1'b0;
  logic        o_word_ready;
  logic [7:0]  o_data;
  logic [1:0]  o_address;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic        o_last;
  wu_state_t   dbg_state;

  always #5 clk = ~clk;

  word_unpacker dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_word(i_word), .i_word_valid(i_word_valid),
    .o_word_ready(o_word_ready), .o_data(o_data), .o_address(o_address),
    .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Model: every accepted word becomes four {lane, byte} entries, lane 0 first.
  logic [9:0]  byte_q[$];
  logic [31:0] exp_q[$];

  logic       s_valid, s_last, s_ready;
  logic [7:0] s_data;
  logic [1:0] s_addr;
  wu_state_t  s_state;
  logic       e_valid, e_last, e_ready;
  logic [7:0] e_data;
  logic [1:0] e_addr;
  wu_state_t  e_state;
  logic       acc, xfer;

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) byte_q.push_back({2'(i), 8'(w >> (8 * i))});
    exp_q.push_back(w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst_n = 1'b0;
    i_word_valid = 1'b0;
    i_ready = 1'b0;
    @(negedge clk);
    i_rst_n = 1'b1;
    byte_q.delete();
    exp_q.delete();
    #1;
  endtask

  // Drive one cycle, sample the DUT, then advance the model by what the
  // model says happens at the coming edge.
  task automatic cycle(input logic wv, input logic [31:0] w, input logic rdy);
    @(negedge clk);
    i_word_valid = wv;
    i_word = w;
    i_ready = rdy;
    #1;
    s_valid = o_valid; s_last = o_last; s_ready = o_word_ready;
    s_data = o_data; s_addr = o_address; s_state = dbg_state;
    e_valid = (byte_q.size() != 0);
    e_data  = e_valid ? byte_q[0][7:0] : 8'h00;
    e_addr  = e_valid ? byte_q[0][9:8] : 2'd0;
    e_last  = e_valid && (e_addr == 2'd3);
    e_state = e_valid ? SEND : IDLE;
`ifdef WORD_UNPACKER_PREFETCH_EN
    e_ready = !e_valid || (byte_q.size() == 1 && rdy);
`else
    e_ready = !e_valid;
`endif
    xfer = e_valid && rdy;
    acc  = wv && e_ready;
    if (xfer) void'(byte_q.pop_front());
    if (acc) push_word(w);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", o_last); end
    n_cmp++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", o_data); end
    n_cmp++; if (o_address !== 2'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", o_address); end
    n_cmp++; if (o_word_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_word_ready); end
    n_cmp++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
  endtask

  task automatic test_basic();
    cycle(1'b1, 32'hDDCCBBAA, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, $urandom(), 1'b1);
      n_cmp++;
      if ({s_valid, s_last, s_ready, s_state} !== {e_valid, e_last, e_ready, e_state} ||
          (e_valid && {s_addr, s_data} !== {e_addr, e_data})) begin
        n_fail++;
        $display("FAIL basic[%0d]: v/l/r=%b%b%b data=%h addr=%0d, want %b%b%b data=%h addr=%0d",
                 i, s_valid, s_last, s_ready, s_data, s_addr, e_valid, e_last, e_ready, e_data, e_addr);
      end
    end
  endtask

  task automatic test_stall();
    cycle(1'b1, 32'hDDCCBBAA, 1'b1);
    cycle(1'b0, $urandom(), 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, $urandom(), 1'b0);
      n_cmp++;
      if (s_valid !== 1'b1 || s_data !== 8'hBB || s_addr !== 2'd1 || s_last !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%b data=%h addr=%0d last=%b, want 1 BB 1 0",
                 i, s_valid, s_data, s_addr, s_last);
      end
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, $urandom(), 1'b1);
      n_cmp++;
      if ({s_valid, s_last, s_ready} !== {e_valid, e_last, e_ready} ||
          (e_valid && {s_addr, s_data} !== {e_addr, e_data})) begin
        n_fail++;
        $display("FAIL stall_drain[%0d]: v/l/r=%b%b%b data=%h addr=%0d, want %b%b%b data=%h addr=%0d",
                 i, s_valid, s_last, s_ready, s_data, s_addr, e_valid, e_last, e_ready, e_data, e_addr);
      end
    end
  endtask

  task automatic test_ignore();
    int n_acc = 0;
    cycle(1'b1, 32'hDDCCBBAA, 1'b1);
    for (int i = 0; i < 14; i++) begin
      if (n_acc == 0) cycle(1'b1, 32'h44332211, 1'b1);
      else cycle(1'b0, $urandom(), 1'b1);
      if (acc) n_acc++;
      n_cmp++;
      if ({s_valid, s_last, s_ready, s_state} !== {e_valid, e_last, e_ready, e_state} ||
          (e_valid && {s_addr, s_data} !== {e_addr, e_data})) begin
        n_fail++;
        $display("FAIL ignore[%0d]: v/l/r=%b%b%b data=%h addr=%0d, want %b%b%b data=%h addr=%0d",
                 i, s_valid, s_last, s_ready, s_data, s_addr, e_valid, e_last, e_ready, e_data, e_addr);
      end
    end
    n_cmp++;
    if (n_acc != 1 || byte_q.size() != 0) begin
      n_fail++;
      $display("FAIL ignore_done: second word accepts=%0d left=%0d, want 1 and 0", n_acc, byte_q.size());
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 32'hDDCCBBAA, 1'b1);
    cycle(1'b0, $urandom(), 1'b1);
    do_reset();
    n_cmp++;
    if (o_valid !== 1'b0 || o_word_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b ready=%b, want 0 1", o_valid, o_word_ready);
    end
    cycle(1'b1, 32'h44332211, 1'b1);
    cycle(1'b0, $urandom(), 1'b1);
    n_cmp++;
    if (s_valid !== 1'b1 || s_addr !== 2'd0 || s_data !== 8'h11) begin
      n_fail++;
      $display("FAIL reset_mid_restart: valid=%b addr=%0d data=%h, want 1 0 11", s_valid, s_addr, s_data);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, $urandom(), 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[2];
    int wi = 0, seen = 0, bubbles = 0, exp_bubbles;
    words[0] = 32'h03020100;
    words[1] = 32'h07060504;
`ifdef WORD_UNPACKER_PREFETCH_EN
    exp_bubbles = 0;
`else
    exp_bubbles = 1;
`endif
    for (int i = 0; i < 16 && seen < 8; i++) begin
      if (wi < 2) cycle(1'b1, words[wi], 1'b1);
      else cycle(1'b0, $urandom(), 1'b1);
      if (acc) wi++;
      if (s_valid) begin
        n_cmp++;
        if (s_data !== 8'(seen)) begin
          n_fail++;
          $display("FAIL b2b_byte[%0d]: got %h want %h", seen, s_data, 8'(seen));
        end
        seen++;
      end else if (seen > 0) begin
        bubbles++;
      end
    end
    n_cmp++;
    if (seen != 8 || bubbles != exp_bubbles) begin
      n_fail++;
      $display("FAIL b2b_bubbles: bytes=%0d bubbles=%0d, want 8 and %0d", seen, bubbles, exp_bubbles);
    end
    cycle(1'b0, $urandom(), 1'b1);
  endtask

  task automatic test_random();
    logic        pending = 1'b0;
    logic [31:0] pw = '0;
    logic [31:0] asm_w = '0;
    logic [31:0] want;
    int sent = 0, got = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 40000 && got < 1000; cyc++) begin
      if (!pending && sent < 1000 && $urandom_range(0, 3) != 0) begin
        pending = 1'b1;
        pw = $urandom();
      end
      cycle(pending, pending ? pw : $urandom(), 1'($urandom_range(0, 1)));
      if (acc) begin pending = 1'b0; sent++; end
      n_cmp++;
      if ({s_valid, s_last, s_ready} !== {e_valid, e_last, e_ready} ||
          (e_valid && {s_addr, s_data} !== {e_addr, e_data})) begin
        n_fail++;
        $display("FAIL rand_cycle[%0d]: v/l/r=%b%b%b data=%h addr=%0d, want %b%b%b data=%h addr=%0d",
                 cyc, s_valid, s_last, s_ready, s_data, s_addr, e_valid, e_last, e_ready, e_data, e_addr);
      end
      if (s_valid && i_ready) begin
        asm_w[8 * s_addr +: 8] = s_data;
        if (s_last) begin
          want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
          n_cmp++;
          if (asm_w !== want) begin
            n_fail++;
            $display("FAIL rand_word[%0d]: got %h want %h", got, asm_w, want);
          end
          got++;
        end
      end
    end
    n_cmp++;
    if (got != 1000) begin
      n_fail++;
      $display("FAIL rand_count: words received %0d want 1000 (cycle budget)", got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule : tb_word_unpacker
